// File: rtl/mux_rr_n.sv
// N-channel registered multiplexer with per-channel valid/ready handshakes.
// Fixed-select or round-robin arbitration feeds a single output register.
module mux_rr_n #(
  parameter int bus_size = 32,
  parameter int channels = 8,
  parameter int sel_bits = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [sel_bits-1:0]          select,
  input  logic [channels*bus_size-1:0] in_data,
  input  logic [channels-1:0]          in_valid,
  output logic [channels-1:0]          in_ready,
  output logic [bus_size-1:0]          out_data,
  output logic [sel_bits-1:0]          out_channel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int                PAD_W = 2 ** (sel_bits + 1);
  localparam logic [sel_bits:0] CHANS = (sel_bits + 1)'(channels);
  localparam logic [sel_bits-1:0] LAST = sel_bits'(channels - 1);

  logic [sel_bits-1:0] ptr;
  logic [PAD_W-1:0]    valid_pad;
  logic [sel_bits:0]   rr_idx;
  logic [sel_bits-1:0] rr_grant_p0;
  logic                rr_any_p0;
  logic                fx_any_p0;
  logic [sel_bits-1:0] grant_p0;
  logic                grant_any_p0;
  logic                load_p0;
  logic [bus_size-1:0] mux_data_p0;

  // Stage p0: arbitration and handshake, all combinational
  always_comb begin
    valid_pad                 = '0;
    valid_pad[channels-1:0]   = in_valid;
    rr_any_p0                 = 1'b0;
    rr_grant_p0               = ptr;
    rr_idx                    = '0;
    // Scan from the far end so the last hit is the one closest to ptr.
    for (int k = channels - 1; k >= 0; k--) begin
      rr_idx = {1'b0, ptr} + (sel_bits + 1)'(k);
      if (rr_idx >= CHANS) rr_idx = rr_idx - CHANS;
      if (valid_pad[rr_idx]) begin
        rr_any_p0   = 1'b1;
        rr_grant_p0 = rr_idx[sel_bits-1:0];
      end
    end
  end

  assign fx_any_p0    = ({1'b0, select} < CHANS) && valid_pad[{1'b0, select}];
  assign grant_p0     = mode ? rr_grant_p0 : select;
  assign grant_any_p0 = mode ? rr_any_p0 : fx_any_p0;
  assign load_p0      = grant_any_p0 && (!out_valid || out_ready);

  always_comb begin
    in_ready    = '0;
    mux_data_p0 = '0;
    for (int i = 0; i < channels; i++) begin
      if (grant_p0 == sel_bits'(i)) begin
        in_ready[i] = rst_n && load_p0;
        mux_data_p0 = in_data[i*bus_size +: bus_size];
      end
    end
  end

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      ptr         <= '0;
    end else if (load_p0) begin
      out_valid   <= 1'b1;
      out_data    <= mux_data_p0;
      out_channel <= grant_p0;
      ptr         <= (grant_p0 == LAST) ? '0 : grant_p0 + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n: a reference arbiter predicts grants and
// queues each accepted word; words are popped when the consumer takes them.
module tb_mux_rr_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [2:0]   select;
  logic [255:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic [31:0]  out_data;
  logic [2:0]   out_channel;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  chd [8];

  logic         mode6;
  logic [2:0]   sel6;
  logic [191:0] in_data6;
  logic [5:0]   v6;
  logic [5:0]   in_ready6;
  logic [31:0]  out_data6;
  logic [2:0]   out_channel6;
  logic         out_valid6;
  logic         rdy6;

  int           checks = 0;
  int           errors = 0;
  logic [2:0]   m_ptr;
  logic         m_ov;
  logic         last_load;
  logic [34:0]  q [$];

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = chd[i];
  end

  always_comb begin
    in_data6 = '0;
    for (int i = 0; i < 6; i++) in_data6[i*32 +: 32] = 32'h6000_0000 + i;
  end

  mux_rr_n #(.bus_size(32), .channels(8), .sel_bits(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_rr_n #(.bus_size(32), .channels(6), .sel_bits(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .select(sel6),
    .in_data(in_data6), .in_valid(v6), .in_ready(in_ready6),
    .out_data(out_data6), .out_channel(out_channel6), .out_valid(out_valid6),
    .out_ready(rdy6)
  );

  function automatic void model_grant(input logic m, input logic [2:0] sel,
                                      input logic [7:0] v, output logic any,
                                      output logic [2:0] g);
    int idx;
    any = 1'b0;
    g   = '0;
    if (!m) begin
      if (v[sel]) begin
        any = 1'b1;
        g   = sel;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        idx = (int'(m_ptr) + k) % 8;
        if (!any && v[idx]) begin
          any = 1'b1;
          g   = 3'(idx);
        end
      end
    end
  endfunction

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic m, input logic [2:0] sel,
                      input logic [7:0] v, input logic ordy);
    logic       any;
    logic [2:0] g;
    logic       ld;
    logic [7:0] exp_rdy;
    logic [34:0] e;
    mode = m; select = sel; in_valid = v; out_ready = ordy;
    #2;
    model_grant(m, sel, v, any, g);
    ld      = any && (!m_ov || ordy);
    exp_rdy = ld ? (8'b1 << g) : 8'b0;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
    end
    if (out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL delivery: got unexpected word %h ch %0d, expected none", out_data, out_channel);
      end else begin
        e = q.pop_front();
        if ({out_channel, out_data} !== e) begin
          errors++;
          $display("FAIL delivery: got ch %0d data %h expected ch %0d data %h",
                   out_channel, out_data, e[34:32], e[31:0]);
        end
      end
    end
    if (ld) q.push_back({g, chd[g]});
    @(posedge clk);
    #1;
    if (ld) begin
      m_ptr = (g == 3'd7) ? 3'd0 : g + 3'd1;
      m_ov  = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    last_load = ld;
    checks++;
    if (out_valid !== m_ov) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
    end
  endtask

  task automatic drain();
    step(1'b1, 3'd0, 8'h00, 1'b1);
    step(1'b1, 3'd0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_channel} !== 36'd0) begin
      errors++;
      $display("FAIL reset_init: got v %b d %h ch %0d expected all zero", out_valid, out_data, out_channel);
    end
    rst_n = 1'b1;
    chd[0] = 32'hDEADBEEF;
    step(1'b0, 3'd0, 8'hFF, 1'b0);
    checks++;
    if (out_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_preload: got %h expected deadbeef", out_data);
    end
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'hFF;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_channel, in_ready} !== 44'd0) begin
      errors++;
      $display("FAIL reset_async: got v %b d %h ch %0d rdy %b expected all zero",
               out_valid, out_data, out_channel, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold_ready: got %b expected 0", in_ready);
    end
    rst_n = 1'b1;
    m_ptr = 3'd0;
    m_ov  = 1'b0;
    q.delete();
    step(1'b1, 3'd0, 8'hFF, 1'b1);
    checks++;
    if (out_channel !== 3'd0) begin
      errors++;
      $display("FAIL reset_first_grant: got %0d expected 0", out_channel);
    end
    drain();
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 8; i++) chd[i] = 32'h11 * i;
    step(1'b0, 3'd5, 8'hFF, 1'b1);
    checks++;
    if (out_data !== 32'h55 || out_channel !== 3'd5) begin
      errors++;
      $display("FAIL fixed_sel5: got ch %0d data %h expected ch 5 data 00000055", out_channel, out_data);
    end
    drain();
    sel6 = 3'd2; v6 = 6'h3F; rdy6 = 1'b1; mode6 = 1'b0;
    #2;
    checks++;
    if (in_ready6 !== 6'b000100) begin
      errors++;
      $display("FAIL fixed6_ready: got %b expected 000100", in_ready6);
    end
    @(posedge clk);
    #1;
    checks++;
    if (!out_valid6 || out_channel6 !== 3'd2 || out_data6 !== 32'h6000_0002) begin
      errors++;
      $display("FAIL fixed6_load: got v %b ch %0d data %h expected v 1 ch 2 data 60000002",
               out_valid6, out_channel6, out_data6);
    end
    sel6 = 3'd7;
    #2;
    checks++;
    if (in_ready6 !== 6'b0) begin
      errors++;
      $display("FAIL fixed6_outofrange_ready: got %b expected 0", in_ready6);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid6 !== 1'b0) begin
      errors++;
      $display("FAIL fixed6_drain: got out_valid %b expected 0", out_valid6);
    end
    v6 = 6'h00;
  endtask

  task automatic test_rr_fairness();
    step(1'b0, 3'd7, 8'hFF, 1'b1);
    drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 3'd0, 8'hFF, 1'b1);
      checks++;
      if (out_channel !== 3'(i % 8)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got %0d expected %0d", i, out_channel, i % 8);
      end
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd0, 8'b1000_0100, 1'b1);
      checks++;
      if (out_channel !== ((i % 2 == 0) ? 3'd2 : 3'd7)) begin
        errors++;
        $display("FAIL rr_alt[%0d]: got %0d expected %0d", i, out_channel, (i % 2 == 0) ? 2 : 7);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    chd[3] = 32'hA5A5A5A5;
    step(1'b0, 3'd3, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd0, 8'hFF, 1'b0);
      checks++;
      if (out_data !== 32'hA5A5A5A5 || out_channel !== 3'd3) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ch %0d data %h expected ch 3 data a5a5a5a5", i, out_channel, out_data);
      end
    end
    step(1'b1, 3'd0, 8'hFF, 1'b1);
    checks++;
    if (out_channel !== 3'd4) begin
      errors++;
      $display("FAIL bp_refill: got %0d expected 4", out_channel);
    end
    drain();
  endtask

  task automatic test_wrap_switch();
    step(1'b1, 3'd0, 8'h80, 1'b1);
    step(1'b0, 3'd2, 8'hFF, 1'b1);
    step(1'b1, 3'd0, 8'hFF, 1'b1);
    checks++;
    if (out_channel !== 3'd3) begin
      errors++;
      $display("FAIL wrap_switch: got %0d expected 3", out_channel);
    end
    drain();
  endtask

  task automatic test_stress();
    chd[1] = 32'h1000_0000;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 3'd0, 8'h02, 1'($urandom_range(0, 1)));
      if (last_load) chd[1] = chd[1] + 32'd1;
    end
    drain();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL stress_leftover: got %0d undelivered words expected 0", q.size());
    end
  endtask

  initial begin
    mode = 1'b0; select = '0; in_valid = '0; out_ready = 1'b0;
    mode6 = 1'b0; sel6 = '0; v6 = '0; rdy6 = 1'b0;
    for (int i = 0; i < 8; i++) chd[i] = '0;
    m_ptr = '0; m_ov = 1'b0; last_load = 1'b0;
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_backpressure();
    test_wrap_switch();
    test_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel registered multiplexer with valid/ready handshakes on every input and on the output. Two selection modes: fixed (an external `select` chooses the channel, as the classic 8:1 datapath mux does) and round-robin (fair arbitration among valid channels). Sits between multiple producers (writeback sources, memory return paths, debug ports) and a single shared consumer in the pipeline. Provides a one-cycle registered output and back-pressure to the losing channels.

## Interface
- `bus_size`, 32, width of each data channel in bits
- `channels`, 8, number of input channels (2..16, need not be a power of two)
- `sel_bits`, 3, width of `select` and `out_channel`; must satisfy 2^sel_bits >= channels

- `clk`  input  1  single clock; all state updates on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `mode`  input  1  0 = fixed select, 1 = round-robin
- `select`  input  sel_bits  channel index used in fixed mode
- `in_data`  input  channels*bus_size  flattened; channel i occupies bits [i*bus_size +: bus_size]
- `in_valid`  input  channels  per-channel valid
- `in_ready`  output  channels  per-channel accept, combinational
- `out_data`  output  bus_size  registered data
- `out_channel`  output  sel_bits  index of the channel that supplied `out_data`
- `out_valid`  output  1  output register holds a word
- `out_ready`  input  1  consumer accepts `out_data` this cycle

## Operation
- **Output register.** Holds one word plus its channel index.
  - `load = grant_any && (!out_valid || out_ready)`.
  - On `load`: `out_data <= in_data[grant]`, `out_channel <= grant`, `out_valid <= 1`.
  - If `out_valid && out_ready && !load`: `out_valid <= 0`. `out_data` and `out_channel` hold their values.
  - While `out_valid && !out_ready`: `out_data` and `out_channel` must not change.
- **Fixed mode** (`mode=0`):
  - Candidate is `select`.
  - `grant_any = (select < channels) && in_valid[select]`.
  - When `select >= channels`, nothing is granted, no channel is accepted, and no error is raised.
- **Round-robin mode** (`mode=1`):
  - Search starts at pointer `ptr` and scans ptr, ptr+1, …, channels-1, 0, …, ptr-1.
  - The first channel with `in_valid` set wins.
  - `grant_any` = any bit of `in_valid` is set.
- **Pointer.**
  - `ptr` is `sel_bits` wide, reset value 0.
  - On every `load`, in either mode: `ptr <= (grant == channels-1) ? 0 : grant+1`.
  - The pointer never takes a value >= channels.
- **Input handshake.**
  - `in_ready[i] = load && (grant == i)`; at most one bit is set per cycle.
  - A word transfers when `in_valid[i] && in_ready[i]`. It is captured exactly once.
  - Producers hold `in_valid` and data until accepted. The block does not depend on that for correctness.
- **Mode switch.** `mode` and `select` are sampled combinationally each cycle. A change affects only the next grant. A word already in the output register is unaffected.
- **Width rules.** No arithmetic on data. The pointer wrap is explicit and does not rely on power-of-two overflow.

## Timing
- Reset (`rst_n` low, asynchronous, any time):
  - `out_valid=0`, `out_data=0`, `out_channel=0`, `ptr=0`.
  - `in_ready` is all-zero while in reset.
  - A held word is discarded.
- Latency: a word accepted at edge t is presented with `out_valid=1` from edge t onward, i.e. usable by the consumer in the cycle after acceptance.
- Throughput: one word per cycle when `out_ready` is held high. The register drains and refills in the same cycle (`out_valid && out_ready && grant_any` gives `load`).
- Back-pressure: while `out_valid && !out_ready`, `in_ready` is all zeros.
- Fairness: in round-robin mode with all channels continuously valid and `out_ready` high, each channel is granted exactly once in every window of `channels` consecutive loads.
- Release of reset: the first grant may occur in the first cycle with `rst_n` high.

## Test plan
- **Reset.** Assert `rst_n=0` mid-transfer with `out_valid=1` and `out_data=32'hDEADBEEF` → `out_valid=0`, `out_data=0`, `out_channel=0`, `in_ready=0` immediately. After release, all channels valid in RR mode → first grant is channel 0.
- **Fixed mode.** `mode=0`, `select=5`, `in_valid=8'hFF`, channel 5 data `32'h0000_0055`, `out_ready=1` → `in_ready=8'b0010_0000`, next cycle `out_data=32'h55`, `out_channel=5`. With `channels=6`, `select=7` → `in_ready=0` and `out_valid` falls after the drain.
- **Round-robin fairness.** `mode=1`, `in_valid=8'hFF` held, `out_ready=1`, 16 cycles → `out_channel` sequence 0,1,…,7,0,…,7. Then with `in_valid=8'b1000_0100` → grants alternate 2,7,2,7.
- **Back-pressure.** Load channel 3 (`32'hA5A5A5A5`), then `out_ready=0` for 4 cycles with `in_valid=8'hFF` → `out_data` and `out_channel` are stable and `in_ready=0` throughout. Raising `out_ready` drains the word and loads channel 4 in the same cycle.
- **Pointer wrap and mode switch.** RR grant of channel 7 → `ptr=0`. Switch to `mode=0`, `select=2`, one load → `ptr=3`. Back to `mode=1` with all channels valid → next grant is channel 3.
- **Single-producer stress.** Only channel 1 valid, random `out_ready` for 200 cycles → every word from a scoreboard is delivered exactly once, in order, with `out_channel=1`.
